// File: rtl/midi_pkg.sv
// Shared MIDI constants, receiver state encoding and message-length helper
// for the MIDI IN front end.
package midi_pkg;

  localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
  localparam logic [7:0] MIDI_SYSCOM_MIN = 8'hF0;
  localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Program change (Cx) and channel pressure (Dx) carry one data byte.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI IN deserialiser: input synchroniser plus a clock-count bit timer that
// samples mid-bit and emits one strobe per correctly framed byte.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int BAUD_CNT    = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_CNT);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_t              state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [2:0]             bit_idx, bit_d;
  logic [7:0]             shreg, shreg_d;
  logic                   strobe_d, ferr_d;

  // Preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], midi_rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_d;
      shreg       <= shreg_d;
      byte_strobe <= strobe_d;
      frame_err   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    bit_d    = bit_idx;
    shreg_d  = shreg;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Half a bit in: a high line means the falling edge was a glitch.
        if (cnt == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            strobe_d = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte = shreg;
  assign busy    = (state != IDLE);

endmodule

// File: rtl/midi_in_parser.sv
// MIDI IN front end: byte receiver plus a channel-voice message parser with
// running status and transparent realtime bytes.
module midi_in_parser
  import midi_pkg::*;
#(
  parameter int BAUD_CNT    = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       frame_err,
  output logic       busy
);

  logic [7:0] rx_byte;
  logic       byte_strobe;
  logic [7:0] run_status;
  logic [7:0] d1_q;
  logic       dcnt;

  midi_uart_rx #(
    .BAUD_CNT   (BAUD_CNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .midi_rx    (midi_rx),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // run_status[7] doubles as "running status valid"; 0 means none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
      msg_len    <= '0;
      rt_valid   <= 1'b0;
      rt_byte    <= '0;
      run_status <= '0;
      d1_q       <= '0;
      dcnt       <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      rt_valid  <= 1'b0;
      if (byte_strobe) begin
        if (rx_byte >= MIDI_RT_MIN) begin
          rt_byte  <= rx_byte;
          rt_valid <= 1'b1;
        end else if (rx_byte >= MIDI_SYSCOM_MIN) begin
          run_status <= '0;
          dcnt       <= 1'b0;
        end else if (rx_byte >= MIDI_STATUS_MIN) begin
          run_status <= rx_byte;
          dcnt       <= 1'b0;
        end else if (run_status[7]) begin
          if (!dcnt && midi_data_len(run_status) == 2'd2) begin
            d1_q <= rx_byte;
            dcnt <= 1'b1;
          end else begin
            msg_valid  <= 1'b1;
            msg_status <= run_status;
            msg_data1  <= dcnt ? d1_q : rx_byte;
            msg_data2  <= dcnt ? rx_byte : 8'h00;
            msg_len    <= dcnt ? 2'd3 : 2'd2;
            dcnt       <= 1'b0;
          end
        end
      end
    end
  end

endmodule
